// File: rtl/trng_conditioner_pipe.sv
// trng_conditioner_pipe
// Multi-round TRNG conditioning controller. It captures raw entropy blocks and
// drives an external hash engine for 1..MAX_ROUNDS chained rounds. Each final
// digest is folded into a persistent pool, and its low OUT_WIDTH bits are
// queued in a first-word fall-through output FIFO. The block also runs a
// repetition-count health test on the raw blocks and a watchdog on the hash
// engine.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   trng_go, op_rounds       request pulse (sampled in IDLE); 0 = INIT, else round count
//   raw_in/raw_valid/raw_ready  raw entropy block handshake
//   hash_go/hash_msg         one-cycle hash start and the held message
//   hash_done/hash_digest    digest return from the hash engine
//   data_out/out_valid/out_ready  FIFO head and pop handshake
//   fifo_level               FIFO occupancy
//   trng_busy/trng_done      activity flag and one-cycle completion pulse
//   health_err/timeout_err   sticky error flags
//   err_clr                  clears the error flags (honoured only in ERROR)
module trng_conditioner_pipe #(
   parameter int unsigned RAW_WIDTH    = 512,
   parameter int unsigned DIGEST_WIDTH = 256,
   parameter int unsigned OUT_WIDTH    = 128,
   parameter int unsigned MAX_ROUNDS   = 4,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned RCT_CUTOFF   = 3,
   parameter int unsigned HASH_TIMEOUT = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              trng_go,
   input  logic [$clog2(MAX_ROUNDS+1)-1:0]   op_rounds,
   input  logic [RAW_WIDTH-1:0]              raw_in,
   input  logic                              raw_valid,
   output logic                              raw_ready,
   output logic                              hash_go,
   output logic [RAW_WIDTH-1:0]              hash_msg,
   input  logic                              hash_done,
   input  logic [DIGEST_WIDTH-1:0]           hash_digest,
   output logic [OUT_WIDTH-1:0]              data_out,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              trng_busy,
   output logic                              trng_done,
   output logic                              health_err,
   output logic                              timeout_err,
   input  logic                              err_clr
);

   localparam int unsigned RW  = $clog2(MAX_ROUNDS + 1);
   localparam int unsigned REP = RAW_WIDTH / DIGEST_WIDTH;
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CW  = $clog2(RCT_CUTOFF + 1);
   localparam int unsigned TW  = $clog2(HASH_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_HASH_REQ, S_HASH_WAIT, S_PUSH, S_ERROR
   } state_t;

   state_t                  state_q, state_n;
   logic [RW-1:0]           rounds_q, rounds_n;
   logic [RW-1:0]           round_idx_q, round_idx_n;
   logic [RAW_WIDTH-1:0]    raw_q, raw_n;
   logic [RAW_WIDTH-1:0]    prev_q, prev_n;
   logic [CW-1:0]           rct_q, rct_n, rct_inc;
   logic [DIGEST_WIDTH-1:0] pool_q, pool_n;
   logic [DIGEST_WIDTH-1:0] digest_q, digest_n;
   logic [RAW_WIDTH-1:0]    msg_q, msg_n;
   logic [TW-1:0]           tmo_q, tmo_n;
   logic                    hash_go_q, hash_go_n;
   logic                    raw_ready_q, raw_ready_n;
   logic                    busy_q, busy_n;
   logic                    done_q, done_n;
   logic                    health_q, health_n;
   logic                    timeout_q, timeout_n;

   // FIFO storage and bookkeeping
   logic [OUT_WIDTH-1:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_n;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_n;
   logic [LW-1:0]           level_q, level_n;
   logic [OUT_WIDTH-1:0]    head_q, head_n;
   logic                    out_valid_q, out_valid_n;
   logic                    fifo_push, fifo_pop, fifo_flush, fifo_full;

   assign fifo_full = (level_q == LW'(FIFO_DEPTH));
   // Run length of identical raw blocks including the one on raw_in
   assign rct_inc   = (raw_in == prev_q) ? rct_q + CW'(1) : CW'(1);

   // Next-state and datapath update logic
   always_comb begin
      state_n     = state_q;
      rounds_n    = rounds_q;
      round_idx_n = round_idx_q;
      raw_n       = raw_q;
      prev_n      = prev_q;
      rct_n       = rct_q;
      pool_n      = pool_q;
      digest_n    = digest_q;
      msg_n       = msg_q;
      tmo_n       = tmo_q;
      health_n    = health_q;
      timeout_n   = timeout_q;
      done_n      = 1'b0;
      fifo_push   = 1'b0;
      fifo_flush  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (trng_go) begin
               if (op_rounds == '0) begin
                  pool_n     = '0;
                  rct_n      = '0;
                  prev_n     = '0;
                  fifo_flush = 1'b1;
                  done_n     = 1'b1;
               end else begin
                  rounds_n    = (op_rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : op_rounds;
                  round_idx_n = RW'(1);
                  state_n     = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (raw_valid && raw_ready_q) begin
               raw_n  = raw_in;
               prev_n = raw_in;
               rct_n  = rct_inc;
               if (rct_inc == CW'(RCT_CUTOFF)) begin
                  health_n = 1'b1;
                  state_n  = S_ERROR;
               end else begin
                  // First round chains from the pool
                  msg_n   = raw_in ^ {REP{pool_q}};
                  state_n = S_HASH_REQ;
               end
            end
         end
         S_HASH_REQ: begin
            tmo_n   = '0;
            state_n = S_HASH_WAIT;
         end
         S_HASH_WAIT: begin
            if (hash_done) begin
               digest_n = hash_digest;
               if (round_idx_q >= rounds_q) begin
                  state_n = S_PUSH;
               end else begin
                  // Later rounds chain from the digest just returned
                  round_idx_n = round_idx_q + RW'(1);
                  msg_n       = raw_q ^ {REP{hash_digest}};
                  state_n     = S_HASH_REQ;
               end
            end else if (tmo_q == TW'(HASH_TIMEOUT - 1)) begin
               timeout_n = 1'b1;
               state_n   = S_ERROR;
            end else begin
               tmo_n = tmo_q + TW'(1);
            end
         end
         S_PUSH: begin
            // Room is judged on the pre-pop level
            if (!fifo_full) begin
               fifo_push = 1'b1;
               pool_n    = digest_q;
               done_n    = 1'b1;
               state_n   = S_IDLE;
            end
         end
         S_ERROR: begin
            if (err_clr) begin
               health_n  = 1'b0;
               timeout_n = 1'b0;
               rct_n     = '0;
               state_n   = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      hash_go_n   = (state_n == S_HASH_REQ);
      raw_ready_n = (state_n == S_LOAD);
      busy_n      = (state_n != S_IDLE);
   end

   // FIFO pointer/level update and registered fall-through head
   always_comb begin
      fifo_pop = (level_q != '0) && out_ready && !fifo_flush;
      if (fifo_flush) begin
         wr_ptr_n = '0;
         rd_ptr_n = '0;
         level_n  = '0;
      end else begin
         wr_ptr_n = wr_ptr_q + PW'(fifo_push);
         rd_ptr_n = rd_ptr_q + PW'(fifo_pop);
         level_n  = level_q + LW'(fifo_push) - LW'(fifo_pop);
      end
      out_valid_n = (level_n != '0);
      if (level_n == '0)
         head_n = '0;
      else if (fifo_push && (wr_ptr_q == rd_ptr_n))
         head_n = digest_q[OUT_WIDTH-1:0];
      else
         head_n = mem_q[rd_ptr_n];
   end

   // FIFO storage array
   always_ff @(posedge clk) begin
      if (fifo_push)
         mem_q[wr_ptr_q] <= digest_q[OUT_WIDTH-1:0];
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rounds_q    <= '0;
         round_idx_q <= '0;
         raw_q       <= '0;
         prev_q      <= '0;
         rct_q       <= '0;
         pool_q      <= '0;
         digest_q    <= '0;
         msg_q       <= '0;
         tmo_q       <= '0;
         hash_go_q   <= 1'b0;
         raw_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         health_q    <= 1'b0;
         timeout_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         head_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         rounds_q    <= rounds_n;
         round_idx_q <= round_idx_n;
         raw_q       <= raw_n;
         prev_q      <= prev_n;
         rct_q       <= rct_n;
         pool_q      <= pool_n;
         digest_q    <= digest_n;
         msg_q       <= msg_n;
         tmo_q       <= tmo_n;
         hash_go_q   <= hash_go_n;
         raw_ready_q <= raw_ready_n;
         busy_q      <= busy_n;
         done_q      <= done_n;
         health_q    <= health_n;
         timeout_q   <= timeout_n;
         wr_ptr_q    <= wr_ptr_n;
         rd_ptr_q    <= rd_ptr_n;
         level_q     <= level_n;
         head_q      <= head_n;
         out_valid_q <= out_valid_n;
      end
   end

   assign raw_ready   = raw_ready_q;
   assign hash_go     = hash_go_q;
   assign hash_msg    = msg_q;
   assign data_out    = head_q;
   assign out_valid   = out_valid_q;
   assign fifo_level  = level_q;
   assign trng_busy   = busy_q;
   assign trng_done   = done_q;
   assign health_err  = health_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_trng_conditioner_pipe.sv
// Testbench for trng_conditioner_pipe: a behavioural hash responder
// (digest = ~msg[255:0]) plus a reference model of pool chaining and the FIFO.
module tb_trng_conditioner_pipe;

   localparam int unsigned RAW_W = 512;
   localparam int unsigned DIG_W = 256;
   localparam int unsigned OUT_W = 128;
   localparam int unsigned MAXR  = 4;
   localparam int unsigned FD    = 2;
   localparam int unsigned RCTC  = 3;
   localparam int unsigned HTO   = 16;
   localparam int unsigned RW    = $clog2(MAXR + 1);
   localparam int unsigned LW    = $clog2(FD + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             trng_go;
   logic [RW-1:0]    op_rounds;
   logic [RAW_W-1:0] raw_in;
   logic             raw_valid;
   logic             raw_ready;
   logic             hash_go;
   logic [RAW_W-1:0] hash_msg;
   logic             hash_done;
   logic [DIG_W-1:0] hash_digest;
   logic [OUT_W-1:0] data_out;
   logic             out_valid;
   logic             out_ready;
   logic [LW-1:0]    fifo_level;
   logic             trng_busy;
   logic             trng_done;
   logic             health_err;
   logic             timeout_err;
   logic             err_clr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   trng_conditioner_pipe #(
      .RAW_WIDTH(RAW_W), .DIGEST_WIDTH(DIG_W), .OUT_WIDTH(OUT_W), .MAX_ROUNDS(MAXR),
      .FIFO_DEPTH(FD), .RCT_CUTOFF(RCTC), .HASH_TIMEOUT(HTO)
   ) dut (
      .clk(clk), .rst(rst), .trng_go(trng_go), .op_rounds(op_rounds),
      .raw_in(raw_in), .raw_valid(raw_valid), .raw_ready(raw_ready),
      .hash_go(hash_go), .hash_msg(hash_msg), .hash_done(hash_done),
      .hash_digest(hash_digest), .data_out(data_out), .out_valid(out_valid),
      .out_ready(out_ready), .fifo_level(fifo_level), .trng_busy(trng_busy),
      .trng_done(trng_done), .health_err(health_err), .timeout_err(timeout_err),
      .err_clr(err_clr)
   );

   // ---------------- hash engine responder ----------------
   int               resp_lat  = 5;
   bit               resp_hold = 1'b0;
   logic             late_done = 1'b0;
   int               go_cnt    = 0;
   logic [RAW_W-1:0] msg_log[$];
   logic             resp_done = 1'b0;
   logic [DIG_W-1:0] resp_dig  = '0;

   assign hash_done   = resp_done | late_done;
   assign hash_digest = resp_dig;

   initial begin : responder
      bit               pend;
      int               cnt;
      logic [RAW_W-1:0] pmsg;
      pend = 1'b0;
      cnt  = 0;
      pmsg = '0;
      forever begin
         @(posedge clk); #1;
         resp_done = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               resp_done = 1'b1;
               resp_dig  = ~pmsg[DIG_W-1:0];
               pend      = 1'b0;
            end
         end
         if (hash_go === 1'b1) begin
            go_cnt++;
            msg_log.push_back(hash_msg);
            if (!resp_hold) begin
               pend = 1'b1;
               cnt  = resp_lat;
               pmsg = hash_msg;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   logic [DIG_W-1:0] ref_pool;
   logic [OUT_W-1:0] ref_fifo[$];

   function automatic logic [RAW_W-1:0] ref_msg(input logic [RAW_W-1:0] raw,
                                                input logic [DIG_W-1:0] chain);
      logic [RAW_W-1:0] m;
      m = raw;
      for (int i = 0; i < int'(RAW_W / DIG_W); i++)
         m[i*DIG_W +: DIG_W] = m[i*DIG_W +: DIG_W] ^ chain;
      return m;
   endfunction

   function automatic logic [DIG_W-1:0] ref_chain(input logic [RAW_W-1:0] raw,
                                                  input logic [DIG_W-1:0] start, input int n);
      logic [DIG_W-1:0] c;
      logic [RAW_W-1:0] m;
      c = start;
      for (int r = 0; r < n; r++) begin
         m = ref_msg(raw, c);
         c = ~m[DIG_W-1:0];
      end
      return c;
   endfunction

   function automatic int eff_rounds(input int r);
      return (r > int'(MAXR)) ? int'(MAXR) : r;
   endfunction

   function automatic logic [RAW_W-1:0] rand_raw();
      logic [RAW_W-1:0] r;
      for (int i = 0; i < int'(RAW_W / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Issue one request; lat = cycle of trng_done, -cycle of an error flag, 0 on budget expiry
   task automatic do_request(input logic [RAW_W-1:0] raw, input int rounds,
                             output int lat, output int gos);
      int base;
      msg_log.delete();
      base      = go_cnt;
      raw_in    = raw;
      raw_valid = 1'b1;
      op_rounds = RW'(rounds);
      trng_go   = 1'b1;
      lat       = 0;
      for (int k = 1; k <= 400; k++) begin
         tick();
         trng_go = 1'b0;
         if (trng_done === 1'b1) begin lat = k; break; end
         if (health_err === 1'b1 || timeout_err === 1'b1) begin lat = -k; break; end
      end
      raw_valid = 1'b0;
      gos       = go_cnt - base;
   endtask

   task automatic pop_word();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (ref_fifo.size() > 0) void'(ref_fifo.pop_front());
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; trng_go = 1'b0; op_rounds = '0; raw_in = '0; raw_valid = 1'b0;
      out_ready = 1'b0; err_clr = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      ref_pool = '0;
      ref_fifo.delete();
      for (int i = 0; i < 10; i++) tick();
      n_checks++;
      if ({raw_ready, hash_go, out_valid, trng_busy, trng_done, health_err, timeout_err} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 0000000",
                  {raw_ready, hash_go, out_valid, trng_busy, trng_done, health_err, timeout_err});
      end
      n_checks++;
      if (fifo_level !== '0 || data_out !== '0 || hash_msg !== '0) begin
         n_fail++;
         $display("FAIL reset_data: level %0d data %h msg_nonzero %b required 0/0/0",
                  fifo_level, data_out, |hash_msg);
      end
   endtask

   task automatic test_single();
      logic [RAW_W-1:0] raw;
      logic [OUT_W-1:0] exp_word;
      int lat, gos;
      raw      = {64{8'hA5}};
      exp_word = {16{8'h5A}};
      resp_lat = 5;
      do_request(raw, 1, lat, gos);
      ref_pool = ref_chain(raw, ref_pool, 1);
      ref_fifo.push_back(ref_pool[OUT_W-1:0]);
      n_checks++;
      if (lat !== 9) begin n_fail++; $display("FAIL single_latency: got %0d required 9", lat); end
      n_checks++;
      if (gos !== 1) begin n_fail++; $display("FAIL single_hash_go: got %0d required 1", gos); end
      n_checks++;
      if (data_out !== exp_word || out_valid !== 1'b1 || fifo_level !== LW'(1)) begin
         n_fail++;
         $display("FAIL single_data: got %h v%b l%0d required %h v1 l1", data_out, out_valid, fifo_level, exp_word);
      end
      pop_word();
      n_checks++;
      if (fifo_level !== '0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_pop: level %0d valid %b required 0/0", fifo_level, out_valid);
      end
   endtask

   task automatic test_multi_round();
      logic [RAW_W-1:0] raw, raw2;
      logic [DIG_W-1:0] d1, d3;
      int lat, gos;
      raw      = rand_raw();
      resp_lat = 3;
      d1       = ref_chain(raw, ref_pool, 1);
      d3       = ref_chain(raw, ref_pool, 3);
      do_request(raw, 3, lat, gos);
      n_checks++;
      if (gos !== 3) begin n_fail++; $display("FAIL multi_hash_go: got %0d required 3", gos); end
      n_checks++;
      if (lat !== 15) begin n_fail++; $display("FAIL multi_latency: got %0d required 15", lat); end
      n_checks++;
      if (msg_log.size() < 2 || msg_log[1] !== (raw ^ {d1, d1})) begin
         n_fail++; $display("FAIL multi_round2_msg: round-2 message does not equal raw ^ {d1,d1}");
      end
      ref_pool = d3;
      ref_fifo.push_back(d3[OUT_W-1:0]);
      n_checks++;
      if (data_out !== d3[OUT_W-1:0]) begin
         n_fail++; $display("FAIL multi_data: got %h required %h", data_out, d3[OUT_W-1:0]);
      end
      pop_word();
      raw2     = rand_raw();
      resp_lat = 2;
      do_request(raw2, 1, lat, gos);
      n_checks++;
      if (msg_log.size() < 1 || msg_log[0] !== (raw2 ^ {d3, d3})) begin
         n_fail++; $display("FAIL pool_chain_msg: next round-1 message does not equal raw ^ {d3,d3}");
      end
      ref_pool = ref_chain(raw2, ref_pool, 1);
      ref_fifo.push_back(ref_pool[OUT_W-1:0]);
      n_checks++;
      if (lat !== 6 || data_out !== ref_fifo[0]) begin
         n_fail++; $display("FAIL pool_chain_data: lat %0d data %h required 6 %h", lat, data_out, ref_fifo[0]);
      end
      pop_word();
   endtask

   task automatic test_random();
      logic [RAW_W-1:0] raw;
      int rounds, n, lat, gos, exp_lat;
      for (int it = 0; it < 8; it++) begin
         raw      = rand_raw();
         rounds   = int'($urandom_range(1, 7));
         n        = eff_rounds(rounds);
         resp_lat = int'($urandom_range(1, 6));
         exp_lat  = 3 + n * (resp_lat + 1);
         do_request(raw, rounds, lat, gos);
         ref_pool = ref_chain(raw, ref_pool, n);
         ref_fifo.push_back(ref_pool[OUT_W-1:0]);
         n_checks++;
         if (lat !== exp_lat || gos !== n) begin
            n_fail++;
            $display("FAIL rand_timing[%0d]: rounds %0d lat %0d gos %0d required %0d %0d", it, rounds, lat, gos, exp_lat, n);
         end
         n_checks++;
         if (data_out !== ref_fifo[0] || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rand_data[%0d]: got %h required %h", it, data_out, ref_fifo[0]);
         end
         pop_word();
      end
   endtask

   task automatic test_rct();
      logic [RAW_W-1:0] raw;
      int lat, gos, done_seen, idle_seen;
      raw      = rand_raw();
      resp_lat = 2;
      for (int i = 0; i < 2; i++) begin
         do_request(raw, 1, lat, gos);
         ref_pool = ref_chain(raw, ref_pool, 1);
         ref_fifo.push_back(ref_pool[OUT_W-1:0]);
         n_checks++;
         if (lat !== 6 || data_out !== ref_fifo[0]) begin
            n_fail++; $display("FAIL rct_pre[%0d]: lat %0d data %h required 6 %h", i, lat, data_out, ref_fifo[0]);
         end
         pop_word();
      end
      do_request(raw, 1, lat, gos);
      n_checks++;
      if (lat !== -2 || health_err !== 1'b1 || gos !== 0) begin
         n_fail++; $display("FAIL rct_trip: lat %0d health %b gos %0d required -2 1 0", lat, health_err, gos);
      end
      done_seen = 0; idle_seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (trng_done !== 1'b0) done_seen++;
         if (trng_busy !== 1'b1) idle_seen++;
      end
      n_checks++;
      if (done_seen != 0 || idle_seen != 0 || fifo_level !== '0) begin
         n_fail++; $display("FAIL rct_error_hold: done %0d idle %0d level %0d required 0 0 0", done_seen, idle_seen, fifo_level);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (health_err !== 1'b0 || trng_busy !== 1'b0) begin
         n_fail++; $display("FAIL rct_clear: health %b busy %b required 0 0", health_err, trng_busy);
      end
      do_request(raw, 1, lat, gos);
      ref_pool = ref_chain(raw, ref_pool, 1);
      ref_fifo.push_back(ref_pool[OUT_W-1:0]);
      n_checks++;
      if (lat !== 6 || data_out !== ref_fifo[0]) begin
         n_fail++; $display("FAIL rct_after_clear: lat %0d data %h required 6 %h", lat, data_out, ref_fifo[0]);
      end
      pop_word();
   endtask

   task automatic test_timeout();
      logic [RAW_W-1:0] raw;
      int lat, gos, base, bad;
      raw       = rand_raw();
      resp_hold = 1'b1;
      base      = go_cnt;
      do_request(raw, 1, lat, gos);
      n_checks++;
      if (lat !== -(3 + int'(HTO)) || timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL timeout_trip: lat %0d terr %b required %0d 1", lat, timeout_err, -(3 + int'(HTO)));
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (trng_busy !== 1'b1) bad++;
      end
      n_checks++;
      if (go_cnt - base !== 1 || bad != 0) begin
         n_fail++; $display("FAIL timeout_single_go: gos %0d not_busy %0d required 1 0", go_cnt - base, bad);
      end
      late_done = 1'b1;
      tick();
      late_done = 1'b0;
      tick();
      n_checks++;
      if (timeout_err !== 1'b1 || trng_busy !== 1'b1 || fifo_level !== '0 || trng_done !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_late_done: terr %b busy %b level %0d done %b required 1 1 0 0",
                  timeout_err, trng_busy, fifo_level, trng_done);
      end
      err_clr = 1'b1;
      tick();
      err_clr   = 1'b0;
      late_done = 1'b1;
      tick();
      late_done = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (trng_busy !== 1'b0 || trng_done !== 1'b0 || fifo_level !== '0 || timeout_err !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL timeout_idle_done: bad cycles %0d required 0", bad); end
      resp_hold = 1'b0;
   endtask

   task automatic test_fifo_full();
      logic [RAW_W-1:0] raw;
      int lat, gos, base, done_seen, idle_seen;
      resp_lat = 2;
      do_request(rand_raw(), 1, lat, gos);
      ref_pool = ref_chain(raw_in, ref_pool, 1);
      ref_fifo.push_back(ref_pool[OUT_W-1:0]);
      do_request(rand_raw(), 0, lat, gos);
      ref_pool = '0;
      ref_fifo.delete();
      n_checks++;
      if (lat !== 1 || fifo_level !== '0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL init_flush: lat %0d level %0d valid %b required 1 0 0", lat, fifo_level, out_valid);
      end
      for (int i = 0; i < 2; i++) begin
         raw = rand_raw();
         do_request(raw, 1, lat, gos);
         ref_pool = ref_chain(raw, ref_pool, 1);
         ref_fifo.push_back(ref_pool[OUT_W-1:0]);
      end
      n_checks++;
      if (fifo_level !== LW'(2) || data_out !== ref_fifo[0]) begin
         n_fail++; $display("FAIL fill: level %0d data %h required 2 %h", fifo_level, data_out, ref_fifo[0]);
      end
      raw       = rand_raw();
      base      = go_cnt;
      raw_in    = raw;
      raw_valid = 1'b1;
      op_rounds = RW'(1);
      trng_go   = 1'b1;
      done_seen = 0; idle_seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         trng_go = 1'b0;
         if (trng_done !== 1'b0) done_seen++;
         if (trng_busy !== 1'b1) idle_seen++;
      end
      raw_valid = 1'b0;
      n_checks++;
      if (done_seen != 0 || idle_seen != 0 || fifo_level !== LW'(2) || go_cnt - base !== 1) begin
         n_fail++;
         $display("FAIL full_stall: done %0d idle %0d level %0d gos %0d required 0 0 2 1",
                  done_seen, idle_seen, fifo_level, go_cnt - base);
      end
      ref_pool = ref_chain(raw, ref_pool, 1);
      pop_word();
      n_checks++;
      if (fifo_level !== LW'(1) || trng_done !== 1'b0 || data_out !== ref_fifo[0]) begin
         n_fail++;
         $display("FAIL full_pop: level %0d done %b data %h required 1 0 %h", fifo_level, trng_done, data_out, ref_fifo[0]);
      end
      ref_fifo.push_back(ref_pool[OUT_W-1:0]);
      tick();
      n_checks++;
      if (fifo_level !== LW'(2) || trng_done !== 1'b1 || trng_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_push: level %0d done %b busy %b required 2 1 0", fifo_level, trng_done, trng_busy);
      end
      pop_word();
      n_checks++;
      if (data_out !== ref_fifo[0] || fifo_level !== LW'(1)) begin
         n_fail++; $display("FAIL full_third_word: got %h required %h", data_out, ref_fifo[0]);
      end
      do_request(rand_raw(), 0, lat, gos);
      ref_pool = '0;
      ref_fifo.delete();
      n_checks++;
      if (lat !== 1 || fifo_level !== '0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL init_after_full: lat %0d level %0d required 1 0", lat, fifo_level);
      end
   endtask

   task automatic test_reset_midop();
      logic [RAW_W-1:0] raw;
      int lat, gos, bad;
      resp_lat = 2;
      raw = rand_raw();
      do_request(raw, 1, lat, gos);
      resp_lat  = 6;
      raw_in    = rand_raw();
      raw_valid = 1'b1;
      op_rounds = RW'(2);
      trng_go   = 1'b1;
      tick();
      trng_go = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #2;
      n_checks++;
      if (trng_busy !== 1'b0 || fifo_level !== '0 || out_valid !== 1'b0 || hash_msg !== '0 || data_out !== '0) begin
         n_fail++; $display("FAIL async_reset: busy %b level %0d valid %b required 0 0 0", trng_busy, fifo_level, out_valid);
      end
      tick();
      rst       = 1'b0;
      raw_valid = 1'b0;
      ref_pool  = '0;
      ref_fifo.delete();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (trng_busy !== 1'b0 || trng_done !== 1'b0 || fifo_level !== '0) bad++;
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL post_reset_done: bad cycles %0d required 0", bad); end
      raw      = rand_raw();
      resp_lat = 3;
      do_request(raw, 2, lat, gos);
      ref_pool = ref_chain(raw, ref_pool, 2);
      ref_fifo.push_back(ref_pool[OUT_W-1:0]);
      n_checks++;
      if (lat !== 11 || data_out !== ref_fifo[0]) begin
         n_fail++; $display("FAIL post_reset_req: lat %0d data %h required 11 %h", lat, data_out, ref_fifo[0]);
      end
      pop_word();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      test_reset();
      test_single();
      test_multi_round();
      test_random();
      test_rct();
      test_timeout();
      test_fifo_full();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/trng_conditioner_pipe.md
Name: trng_conditioner_pipe

Overview:
- Parametrised multi-round TRNG conditioning controller with an integrated datapath.
- Captures raw entropy blocks and drives an external hash engine for 1..MAX_ROUNDS chained rounds, chaining each digest into a persistent pool.
- Runs a repetition-count health test and a hash timeout watchdog.
- Buffers conditioned words in an output FIFO with valid/ready handshake. Sits between the entropy source and the SHA core, replacing the fixed 128-bit single-shot top.

Parameters:
- RAW_WIDTH, 512, raw entropy block and hash message width; must be a multiple of DIGEST_WIDTH.
- DIGEST_WIDTH, 256, hash digest width.
- OUT_WIDTH, 128, conditioned output word; OUT_WIDTH <= DIGEST_WIDTH.
- MAX_ROUNDS, 4, maximum conditioning rounds per request.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2.
- RCT_CUTOFF, 3, consecutive identical raw blocks that trip the health error; >= 2.
- HASH_TIMEOUT, 1024, maximum cycles spent in HASH_WAIT.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- trng_go  in  1  request pulse; sampled only in IDLE.
- op_rounds  in  $clog2(MAX_ROUNDS+1)  0 = INIT; 1..MAX_ROUNDS = round count; values above MAX_ROUNDS are clamped to MAX_ROUNDS.
- raw_in  in  RAW_WIDTH  entropy block.
- raw_valid  in  1  raw_in valid.
- raw_ready  out  1  block accepted when raw_valid & raw_ready.
- hash_go  out  1  one-cycle hash start.
- hash_msg  out  RAW_WIDTH  hash message; registered and held stable until hash_done.
- hash_done  in  1  digest valid pulse.
- hash_digest  in  DIGEST_WIDTH  digest.
- data_out  out  OUT_WIDTH  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  pop when out_valid & out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupancy.
- trng_busy  out  1  state != IDLE.
- trng_done  out  1  one-cycle completion pulse.
- health_err  out  1  sticky repetition-count failure.
- timeout_err  out  1  sticky hash timeout.
- err_clr  in  1  clears errors; effective only in ERROR.

Behaviour:
- Reset state: all outputs 0, state IDLE, FIFO empty, pool = 0, rct_cnt = 0, previous-block register = 0.
- States: IDLE, LOAD, HASH_REQ, HASH_WAIT, PUSH, ERROR.
- IDLE, trng_go with op_rounds = 0 (INIT): in a single cycle, clear pool, rct_cnt and previous block; flush the FIFO. trng_done pulses the next cycle; state stays IDLE.
- IDLE, trng_go with op_rounds != 0: latch the round count and enter LOAD the next cycle. trng_go outside IDLE is ignored.
- LOAD:
  - raw_ready = 1. On handshake, capture raw_reg = raw_in.
  - RCT: if raw_in equals the previous accepted block, rct_cnt++; otherwise rct_cnt = 1. The previous block is then updated.
  - If the new rct_cnt == RCT_CUTOFF, go to ERROR and set health_err. Otherwise go to HASH_REQ.
- HASH_REQ:
  - hash_go = 1 for exactly one cycle.
  - hash_msg = raw_reg XOR (RAW_WIDTH/DIGEST_WIDTH replicated copies of chain), where chain = pool on round 1 and the previous round's digest on later rounds.
  - Next state is HASH_WAIT; the timeout counter clears to 0.
- HASH_WAIT:
  - On hash_done, capture hash_digest into digest_reg.
  - If more rounds remain, go to HASH_REQ; after the last round, go to PUSH.
  - The counter increments each cycle without hash_done. When it reaches HASH_TIMEOUT, go to ERROR and set timeout_err; hash_go is not reissued.
  - hash_done in any other state is ignored.
- PUSH:
  - Write digest_reg[OUT_WIDTH-1:0] to the FIFO and set pool = digest_reg, but only when the FIFO is not full. A pop in the same cycle does not make room.
  - While full, stay in PUSH with trng_busy = 1.
  - After the write, go to IDLE; trng_done = 1 in the first IDLE cycle.
- ERROR:
  - No FIFO write, no trng_done; pool is unchanged.
  - err_clr: clear both error flags and rct_cnt, then go to IDLE the next cycle. Only Reset or err_clr leaves ERROR.
- FIFO:
  - First-word fall-through.
  - Simultaneous push and pop leaves the level unchanged.
  - Pop when empty is ignored; pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: asynchronous return to the reset state. A hash_done arriving after reset is ignored.
- Latency, raw_valid already high and hash latency L cycles from hash_go to hash_done: trng_done at 3 + N·(L+1) cycles after the trng_go cycle, where N = rounds.

Test Plan:
- Reset, then idle for 10 cycles -> every output 0, fifo_level = 0, raw_ready = 0.
- op_rounds = 1, raw_in = {64{8'hA5}}, bench hash = ~msg[255:0] with L = 5 -> data_out = ~(128'hA5…A5 ^ 0), trng_done 9 cycles after go, one hash_go pulse.
- op_rounds = 3 -> exactly 3 hash_go pulses. Round-2 hash_msg = raw ^ {digest1, digest1}. Pool equals digest3; the next request's round-1 msg = raw ^ {digest3, digest3}.
- RCT_CUTOFF = 3, three requests with identical raw_in -> health_err rises on the third LOAD handshake, no push, trng_done absent. err_clr -> IDLE; a fourth request succeeds.
- HASH_TIMEOUT = 16, hash_done withheld -> timeout_err after 16 HASH_WAIT cycles, single hash_go. A late hash_done is ignored.
- FIFO_DEPTH = 2, out_ready = 0, three requests -> third holds in PUSH with trng_busy = 1. Popping one word frees space: push occurs, then trng_done. INIT afterwards gives fifo_level = 0.
